// File: rtl/turn_signal_fsm_pkg.sv
// rtl/turn_signal_fsm_pkg.sv - shared state encodings and switch-request decode for the turn-signal path
package turn_signal_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        HAZARDS    = 3'b001,
        TURN_LEFT  = 3'b010,
        TURN_RIGHT = 3'b011
    } state_t;

    // SW[1] = left, SW[0] = right; both together request hazards.
    function automatic state_t decode_req(input logic [1:0] sw);
        state_t req;
        case (sw)
            2'b10:   req = TURN_LEFT;
            2'b01:   req = TURN_RIGHT;
            2'b11:   req = HAZARDS;
            default: req = IDLE;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - divides the system clock down to a one-cycle blink tick at TICK_HZ
module tick_divider #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 4
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_divider: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Tick is registered one count early so it is high exactly while count == DIV-1.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == CW'(DIV - 1))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            r_tick <= (r_cnt == CW'(DIV - 2));
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/turn_signal_fsm.sv
// rtl/turn_signal_fsm.sv - switch sync, blink tick and IDLE/HAZARDS/TURN state register for the tail lights
module turn_signal_fsm
    import turn_signal_fsm_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] SW,
    output logic [2:0] CurrentState,
    output logic [1:0] step,
    output logic       tick
);

    logic       w_tick;
    state_t     w_req;
    logic [1:0] r_sw_meta;
    logic [1:0] r_sw_sync;
    state_t     r_state;
    logic [1:0] r_step;

    tick_divider #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_divider (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (w_tick)
    );

    assign w_req = decode_req(r_sw_sync);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sw_meta <= 2'b00;
            r_sw_sync <= 2'b00;
            r_state   <= IDLE;
            r_step    <= 2'd0;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        r_state <= w_req;
                        r_step  <= 2'd0;
                    end
                    HAZARDS: begin
                        if (w_req == HAZARDS) begin
                            r_step <= {1'b0, ~r_step[0]};
                        end else begin
                            r_state <= w_req;
                            r_step  <= 2'd0;
                        end
                    end
                    TURN_LEFT, TURN_RIGHT: begin
                        // Hazards cut in at once; any other change waits for the sequence to finish.
                        if (w_req == HAZARDS) begin
                            r_state <= HAZARDS;
                            r_step  <= 2'd0;
                        end else if (r_step == 2'd3) begin
                            r_state <= w_req;
                            r_step  <= 2'd0;
                        end else begin
                            r_step <= r_step + 2'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_step  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign CurrentState = r_state;
    assign step         = r_step;
    assign tick         = w_tick;

endmodule

// File: doc/turn_signal_fsm.md
Name: turn_signal_fsm

Overview:
- Control stage directly upstream of the tail-light output logic.
- Synchronises the SW requests and generates a slow blink tick from CLOCK_50.
- Runs the IDLE/HAZARDS/TURN_LEFT/TURN_RIGHT state register and produces the CurrentState[2:0] bus consumed downstream.
- Also exports a per-state step counter and the tick pulse, so the output stage can be driven by a single decided phase.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 4, blink step rate in Hz; DIV = CLK_HZ/TICK_HZ, and DIV must be >= 2 (elaboration error otherwise).

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- SW  input  2  raw switch requests: SW[1] = left, SW[0] = right; both set = hazards.
- CurrentState  output  3  IDLE=3'b000, HAZARDS=3'b001, TURN_LEFT=3'b010, TURN_RIGHT=3'b011; bit 2 always 0.
- step  output  2  phase within the current state.
- tick  output  1  one-cycle pulse at TICK_HZ.

Behaviour:
- Reset is synchronous: with reset high at an edge, the next outputs are CurrentState=IDLE, step=0, tick=0, divider count=0, sync flops=0. Reset has priority over everything, including mid-sequence and a coincident tick.
- Input sync: SW passes through 2 flops per bit. A request is visible to the FSM 2 cycles after the SW change. Raw SW never feeds next-state logic.
- Request decode from synced SW (req):
  - 00 -> IDLE
  - 10 -> TURN_LEFT
  - 01 -> TURN_RIGHT
  - 11 -> HAZARDS
- Divider:
  - Counter runs 0..DIV-1 and wraps to 0.
  - tick=1 for exactly the cycle in which count==DIV-1 (registered output).
  - First tick after reset is on cycle DIV.
- State and step change only on cycles where tick=1; otherwise they hold.
- Transitions on tick:
  - IDLE: next=req, step=0.
  - HAZARDS:
    - if req==HAZARDS: stay, step[0] toggles, step[1] stays 0;
    - else next=req, step=0.
  - TURN_LEFT / TURN_RIGHT:
    - if req==HAZARDS: next=HAZARDS, step=0 (hazards preempt immediately);
    - else if step==3: next=req, step=0 (a turn sequence always completes; the same req restarts it at 0);
    - else stay, step=step+1.
- Direction change mid-sequence (left->right) takes effect only at the wrap. Releasing the switch mid-sequence also waits for the wrap, then goes to IDLE.
- Outputs are registered. CurrentState/step update on the edge ending the tick cycle, so downstream sees the new value one cycle after tick is high.
- Widths: step is 2-bit and wraps naturally. CurrentState encodings outside 000..011 are never produced; a defensive default returns to IDLE.

Decomposition:
- Shared package: state encodings IDLE/HAZARDS/TURN_LEFT/TURN_RIGHT (3-bit). The output logic stage uses the same constants.
- One sub-module: tick_divider (parameters CLK_HZ, TICK_HZ; ports CLOCK_50, reset, tick).
- Synchroniser, decode and FSM stay in turn_signal_fsm.

Test Plan (CLK_HZ=8, TICK_HZ=2, so DIV=4):
- Reset held 3 cycles, SW=00 -> CurrentState=000, step=0; tick first high on cycle 4 after reset release, then every 4 cycles, width 1.
- SW=10 held -> on the first tick after sync, CurrentState=010, step=0. Subsequent ticks give step 1, 2, 3, 0 (state 010 throughout).
- SW=10, then SW=01 when step=1 -> stays 010 through steps 2 and 3; at the wrap tick CurrentState=011, step=0.
- SW=01 with step=2, then SW=11 -> on the next tick CurrentState=001, step=0; further ticks give step 1, 0, 1. SW=00 -> next tick IDLE, step=0.
- SW pulse of 1 cycle between ticks -> no state change (synced value back to 00 by the tick); SW stable for 2+ cycles before a tick -> accepted.
- reset asserted mid TURN_LEFT at step=2, coincident with tick -> next cycle CurrentState=000, step=0, divider restarts; first tick again at cycle 4.
